// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, offsettable syncs
// with selectable polarity, and single-cycle line/frame/vblank event strobes.
// Advances only on clk edges qualified by the clk_pix enable.
module video_timing_gen #(
   parameter int   W          = 9,
   parameter int   H_TOTAL    = 512,
   parameter int   H_BL_START = 256,
   parameter int   HS_START   = 336,
   parameter int   HS_END     = 376,
   parameter int   V_TOTAL    = 256,
   parameter int   V_BL_START = 240,
   parameter int   V_BL_END   = 16,
   parameter int   VS_START   = 4,
   parameter int   VS_END     = 8,
   parameter logic HS_POL     = 1'b1,
   parameter logic VS_POL     = 1'b1,
   parameter int   OFS_W      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_pix,
   input  logic signed [OFS_W-1:0] h_offset,
   input  logic signed [OFS_W-1:0] v_offset,
   output logic [W-1:0]            hc,
   output logic [W-1:0]            vc,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    hbl,
   output logic                    vbl,
   output logic                    line_start,
   output logic                    frame_start,
   output logic                    vbl_start,
   output logic                    field
);

   // Elaboration-time parameter legality
   if (H_TOTAL > (1 << W) || V_TOTAL > (1 << W)) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
   end
   if (!(HS_START < HS_END && HS_END < H_TOTAL)) begin : g_bad_hs
      $error("video_timing_gen: need HS_START < HS_END < H_TOTAL");
   end
   if (!(VS_START < VS_END && VS_END < V_TOTAL)) begin : g_bad_vs
      $error("video_timing_gen: need VS_START < VS_END < V_TOTAL");
   end
   // A single add/subtract correction wraps the offset window, so the
   // offset magnitude must stay below one line/frame.
   if ((1 << (OFS_W - 1)) > H_TOTAL || (1 << (OFS_W - 1)) > V_TOTAL) begin : g_bad_ofs
      $error("video_timing_gen: OFS_W too wide for the raster size");
   end

   localparam logic [W-1:0] H_MAX  = W'(H_TOTAL - 1);
   localparam logic [W-1:0] V_MAX  = W'(V_TOTAL - 1);
   localparam logic [W-1:0] H_BL_S = W'(H_BL_START);
   localparam logic [W-1:0] V_BL_S = W'(V_BL_START);
   localparam logic [W-1:0] V_BL_E = W'(V_BL_END);
   // Flag values decoded at h=0, v=0, loaded while in reset
   localparam logic HBL_RST = (H_BL_START == 0);
   localparam logic VBL_RST = (V_BL_START == 0) || (V_BL_END > 0);

   logic [W-1:0]            h_reg, v_reg, h_next, v_next;
   logic                    h_wrap, v_wrap;
   logic                    line_evt, frame_evt, vbl_evt;
   logic signed [OFS_W-1:0] hofs_reg, vofs_reg;
   logic signed [OFS_W-1:0] ofs_eff [2];
   logic [W-1:0]            cnt_next [2];
   logic [1:0]              in_win;
   logic                    hbl_next, vbl_next, hsync_next, vsync_next;
   logic                    hbl_reg, vbl_reg, hsync_reg, vsync_reg;
   logic                    line_reg, frame_reg, vbls_reg, field_reg;

   // Counter advance and event detection for the coming clk edge
   always_comb begin
      h_wrap    = (h_reg == H_MAX);
      v_wrap    = (v_reg == V_MAX);
      h_next    = h_reg;
      v_next    = v_reg;
      line_evt  = 1'b0;
      frame_evt = 1'b0;
      vbl_evt   = 1'b0;
      if (clk_pix) begin
         if (h_wrap) begin
            h_next    = '0;
            v_next    = v_wrap ? '0 : v_reg + W'(1);
            line_evt  = 1'b1;
            frame_evt = v_wrap;
            vbl_evt   = (v_next == V_BL_S);
         end else begin
            h_next = h_reg + W'(1);
         end
      end
   end

   // The frame being entered uses the freshly sampled offset, so the
   // whole frame from pixel (0,0) onward sees one consistent window.
   assign ofs_eff[0]  = frame_evt ? h_offset : hofs_reg;
   assign ofs_eff[1]  = frame_evt ? v_offset : vofs_reg;
   assign cnt_next[0] = h_next;
   assign cnt_next[1] = v_next;

   // One sync-window decoder per axis (0 = horizontal, 1 = vertical)
   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int TOT   = (gi == 0) ? H_TOTAL  : V_TOTAL;
      localparam int START = (gi == 0) ? HS_START : VS_START;
      localparam int STOP  = (gi == 0) ? HS_END   : VS_END;

      int           start_i, stop_i;
      logic [W-1:0] win_start, win_stop;

      // Offset window edges, wrapped back into 0..TOT-1
      always_comb begin
         start_i = START + int'(ofs_eff[gi]);
         stop_i  = STOP + int'(ofs_eff[gi]);
         if (start_i < 0)        start_i = start_i + TOT;
         else if (start_i >= TOT) start_i = start_i - TOT;
         if (stop_i < 0)         stop_i = stop_i + TOT;
         else if (stop_i >= TOT) stop_i = stop_i - TOT;
         win_start = W'(start_i);
         win_stop  = W'(stop_i);
      end

      // A start above the stop means the window straddles the wrap
      assign in_win[gi] = (win_start <= win_stop)
                        ? (cnt_next[gi] >= win_start && cnt_next[gi] < win_stop)
                        : (cnt_next[gi] >= win_start || cnt_next[gi] < win_stop);
   end

   assign hbl_next   = (h_next >= H_BL_S);
   assign vbl_next   = (v_next >= V_BL_S) || ((V_BL_END != 0) && (v_next < V_BL_E));
   assign hsync_next = in_win[0] ? HS_POL : ~HS_POL;
   assign vsync_next = in_win[1] ? VS_POL : ~VS_POL;

   // Counter, decoded-flag, strobe and offset-shadow registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_reg     <= '0;
         v_reg     <= '0;
         hofs_reg  <= '0;
         vofs_reg  <= '0;
         hbl_reg   <= HBL_RST;
         vbl_reg   <= VBL_RST;
         hsync_reg <= ~HS_POL;
         vsync_reg <= ~VS_POL;
         line_reg  <= 1'b0;
         frame_reg <= 1'b0;
         vbls_reg  <= 1'b0;
         field_reg <= 1'b0;
      end else begin
         h_reg     <= h_next;
         v_reg     <= v_next;
         hbl_reg   <= hbl_next;
         vbl_reg   <= vbl_next;
         hsync_reg <= hsync_next;
         vsync_reg <= vsync_next;
         line_reg  <= line_evt;
         frame_reg <= frame_evt;
         vbls_reg  <= vbl_evt;
         if (frame_evt) begin
            hofs_reg  <= h_offset;
            vofs_reg  <= v_offset;
            field_reg <= ~field_reg;
         end
      end
   end

   assign hc          = h_reg;
   assign vc          = v_reg;
   assign hbl         = hbl_reg;
   assign vbl         = vbl_reg;
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign line_start  = line_reg;
   assign frame_start = frame_reg;
   assign vbl_start   = vbls_reg;
   assign field       = field_reg;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 256x224 raster timing generator.
- Produces horizontal/vertical counters, blanking and sync from a single system clock gated by a pixel clock enable.
- Adds runtime sync-position offsets (screen centring from the OSD), selectable sync polarity, and single-cycle line/frame/vblank event strobes for CPU interrupts and line-buffer control.
- Sits between the core clock domain and the video mixer / scan-doubler.

Parameters:
- W, 9, counter width in bits.
- H_TOTAL, 512, pixels per line; h counts 0..H_TOTAL-1.
- H_BL_START, 256, first hblank pixel; hblank runs to end of line.
- HS_START, 336, first hsync pixel before offset.
- HS_END, 376, first pixel after hsync before offset.
- V_TOTAL, 256, lines per frame; v counts 0..V_TOTAL-1.
- V_BL_START, 240, first vblank line.
- V_BL_END, 16, first active line; vblank spans the frame wrap.
- VS_START, 4, first vsync line before offset.
- VS_END, 8, first line after vsync before offset.
- HS_POL, 1, hsync active level.
- VS_POL, 1, vsync active level.
- OFS_W, 4, width of the signed offset inputs.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_pix  in  1  pixel clock enable; all state advances only on clk edges with clk_pix=1.
- h_offset  in  OFS_W  signed; shifts the hsync window, in pixels.
- v_offset  in  OFS_W  signed; shifts the vsync window, in lines.
- hc  out  W  horizontal counter.
- vc  out  W  vertical counter.
- hsync  out  1  horizontal sync, level per HS_POL.
- vsync  out  1  vertical sync, level per VS_POL.
- hbl  out  1  horizontal blank.
- vbl  out  1  vertical blank.
- line_start  out  1  one clk wide strobe when h wraps to 0.
- frame_start  out  1  one clk wide strobe when h and v both wrap to 0.
- vbl_start  out  1  one clk wide strobe when vbl rises.
- field  out  1  toggles at every frame_start.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - h=0, v=0, field=0, strobes=0.
  - Flags decode (h=0, v=0): hbl=0, vbl=1 with defaults, syncs inactive.
  - Shadow offsets = 0.
- Counting, on a clk edge with clk_pix=1:
  - h = (h==H_TOTAL-1) ? 0 : h+1.
  - At h wrap: v = (v==V_TOTAL-1) ? 0 : v+1.
  - With clk_pix=0 all state holds and strobes drop to 0.
- Output decode:
  - hbl, vbl, hsync and vsync are registered decodes of the next counter values, so they align with hc/vc in the same cycle. There is no extra latency.
  - hbl = h >= H_BL_START.
  - vbl = (v >= V_BL_START) || (v < V_BL_END). If V_BL_END=0, vbl = v >= V_BL_START.
  - hsync window: h in [HS_START+hofs, HS_END+hofs). vsync window: v in [VS_START+vofs, VS_END+vofs).
  - Offset sums are sign-extended to W+1 bits, then wrapped modulo the respective total.
  - A window whose start exceeds its end after wrap covers the line/frame wrap.
  - In window: output = POL; out of window: ~POL.
- Offset shadowing:
  - h_offset and v_offset are sampled into shadow registers (hofs, vofs) only at frame_start.
  - A mid-frame change takes effect on the next frame, never mid-line.
- Strobes:
  - Asserted for exactly the one clk cycle following the clk_pix edge that produced the event.
  - frame_start implies line_start in the same cycle.
  - vbl_start fires on the line V_BL_START at h=0.
- Boundary cases:
  - Simultaneous h and v wrap produces line_start + frame_start + field toggle together.
  - Reset asserted mid-frame clears everything immediately, without waiting for clk.
  - clk_pix held high continuously gives a one-pixel-per-clk rate.
- Parameter legality (checked by a generate-time assertion; illegal sets are not supported):
  - H_TOTAL <= 2^W and V_TOTAL <= 2^W.
  - HS_START < HS_END < H_TOTAL, and the same for the vertical window.

Test Plan:
- Reset, then run with clk_pix 1-in-4 -> hc steps every 4th clk; hc=511->0 advances vc; line_start high for one clk at that edge only.
- Full frame with defaults, offsets 0:
  - hbl high for hc 256..511.
  - hsync=1 for hc 336..375.
  - vbl high for vc 240..255 and 0..15.
  - vsync=1 for vc 4..7.
  - vbl_start once at vc=240, hc=0.
- h_offset=-3 and v_offset=+2 written mid-frame -> current frame unchanged. From the next frame: hsync covers hc 333..372 and vsync covers vc 6..9.
- HS_POL=0, VS_POL=0 build -> sync outputs inverted, low inside the windows; reset value is 1.
- Frame wrap (vc=255, hc=511 -> 0,0) -> line_start, frame_start and field toggle in the same cycle; field alternates 0,1,0 over 3 frames.
- Assert reset at vc=100, hc=50, mid-clk-phase -> outputs reach reset values before the next clk edge; counting restarts from 0,0 after release.
